// File: rtl/oam_dma_ctl.sv
// Sprite-DMA sequencer and memory-bus arbiter. It takes over the CPU bus when the CPU
// writes the trigger address, then copies one 256-byte page to the OAM data port.
module oam_dma_ctl #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_addr_l,
  input  logic [7:0] cpu_addr_h,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_rdy,
  output logic [7:0] mem_addr_l,
  output logic [7:0] mem_addr_h,
  output logic       mem_rw,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       dma_busy
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state;
  logic       put;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       rdy_q;
  logic       busy_q;
  logic       trigger;

  assign trigger = (state == IDLE) && !cpu_rw &&
                   ({cpu_addr_h, cpu_addr_l} == TRIGGER_ADDR);

  // The put flop runs freely, so a DMA must line its reads up with the get phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      put    <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      latch  <= 8'h00;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      put <= ~put;
      case (state)
        IDLE: begin
          if (trigger) begin
            page   <= cpu_wdata;
            idx    <= 8'h00;
            state  <= HALT;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        HALT:  state <= put ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          latch <= mem_rdata;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            idx    <= 8'h00;
            state  <= IDLE;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr_h = cpu_addr_h;
    mem_addr_l = cpu_addr_l;
    mem_rw     = cpu_rw;
    mem_wdata  = cpu_wdata;
    case (state)
      IDLE: begin
      end
      // Dummy cycles keep the stalled CPU's address on the bus but force a read.
      HALT, ALIGN: begin
        mem_rw    = 1'b1;
        mem_wdata = latch;
      end
      READ: begin
        mem_addr_h = page;
        mem_addr_l = idx;
        mem_rw     = 1'b1;
        mem_wdata  = latch;
      end
      WRITE: begin
        mem_addr_h = OAM_DATA_ADDR[15:8];
        mem_addr_l = OAM_DATA_ADDR[7:0];
        mem_rw     = 1'b0;
        mem_wdata  = latch;
      end
      default: begin
      end
    endcase
  end

  assign cpu_rdy  = rdy_q;
  assign dma_busy = busy_q;

endmodule
